// File: rtl/scramble_mixer.sv
// Complex chip mixer: multiplies spread I/Q chips by the (+-1 +-j) long code,
// saturates, and restarts the scrambler at every radio-frame boundary.
module scramble_mixer #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned FRAME_LEN = 38400,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_i,
    input  logic [WIDTH-1:0]   in_q,
    output logic               scr_enable,
    output logic               scr_reset,
    input  logic [1:0]         scr_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_i,
    output logic [WIDTH:0]     out_q,
    output logic               frame_start
);

    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned OW = WIDTH + 1;
    localparam logic [CNT_W-1:0]    LAST_CHIP = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [EW-1:0] SAT_MAX  = EW'((2 ** WIDTH) - 1);
    localparam logic signed [EW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       chip_cnt, chip_cnt_d;
    logic                   out_valid_d;
    logic [OW-1:0]          out_i_d, out_q_d;
    logic                   frame_start_d;
    logic                   accept;

    logic signed [EW-1:0]   ext_i, ext_q;
    logic signed [EW-1:0]   i_c, q_d, i_d, q_c;
    logic signed [EW-1:0]   re_full, im_full;
    logic [OW-1:0]          re_sat, im_sat;

    function automatic logic [OW-1:0] saturate(input logic signed [EW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OW-1:0];
        end
        return v[OW-1:0];
    endfunction

    // Complex multiply by the +-1 code signs; a code bit of 1 means +1.
    always_comb begin
        ext_i   = {{2{in_i[WIDTH-1]}}, in_i};
        ext_q   = {{2{in_q[WIDTH-1]}}, in_q};
        i_c     = scr_code[1] ? ext_i : -ext_i;
        q_d     = scr_code[0] ? ext_q : -ext_q;
        i_d     = scr_code[0] ? ext_i : -ext_i;
        q_c     = scr_code[1] ? ext_q : -ext_q;
        re_full = i_c - q_d;
        im_full = i_d + q_c;
        re_sat  = saturate(re_full);
        im_sat  = saturate(im_full);
    end

    // Next-state, handshake and frame bookkeeping.
    always_comb begin
        state_d       = state_q;
        chip_cnt_d    = chip_cnt;
        out_valid_d   = out_valid;
        out_i_d       = out_i;
        out_q_d       = out_q;
        frame_start_d = frame_start;
        in_ready      = 1'b0;
        scr_reset     = 1'b0;
        accept        = 1'b0;
        scr_enable    = 1'b0;

        case (state_q)
            INIT: begin
                scr_reset = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
            end
            default: state_d = INIT;
        endcase

        accept     = in_valid && in_ready;
        scr_enable = accept;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d   = 1'b1;
            out_i_d       = re_sat;
            out_q_d       = im_sat;
            frame_start_d = (chip_cnt == '0);
            if (chip_cnt == LAST_CHIP) begin
                chip_cnt_d = '0;
                state_d    = INIT;
            end else begin
                chip_cnt_d = chip_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            chip_cnt    <= '0;
            out_valid   <= 1'b0;
            out_i       <= '0;
            out_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            chip_cnt    <= chip_cnt_d;
            out_valid   <= out_valid_d;
            out_i       <= out_i_d;
            out_q       <= out_q_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_scramble_mixer.sv
// Bench for scramble_mixer: directed vectors, corner sequences and a random
// stream checked by a transaction-level reference model with a code generator.
module tb_scramble_mixer;

    localparam int W  = 12;
    localparam int FL = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_i, in_q;
    logic           scr_enable;
    logic           scr_reset;
    logic [1:0]     scr_code;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     out_i, out_q;
    logic           frame_start;

    scramble_mixer #(.WIDTH(W), .FRAME_LEN(FL), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q),
        .scr_enable(scr_enable), .scr_reset(scr_reset), .scr_code(scr_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scrambler stand-in: arbitrary non-periodic code per phase.
    function automatic logic [1:0] seq_code(input int p);
        logic [31:0] h;
        h = 32'(p) * 32'h9E37_79B1;
        return h[31:30];
    endfunction

    int         phase = 0;
    bit         force_code_en = 1'b1;
    logic [1:0] force_code = 2'b00;

    always @(posedge clk) begin
        if (scr_reset)       phase <= 0;
        else if (scr_enable) phase <= phase + 1;
    end

    assign scr_code = force_code_en ? force_code : seq_code(phase);

    function automatic int sat(input int v);
        int lim;
        lim = 1 << W;
        if (v > lim - 1) return lim - 1;
        if (v < -lim)    return -lim;
        return v;
    endfunction

    // Reference model: queue of expected output chips plus frame position.
    typedef struct { int i; int q; bit fs; } exp_t;
    exp_t expq[$];
    bit   exp_init = 1'b1;
    int   pos = 0;
    int   n_scr_reset = 0;
    int   n_fs = 0;
    bit   m_valid, m_ready, m_acc;
    int   c, d, si, sq;

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            exp_init = 1'b1;
            pos = 0;
        end else begin
            m_valid = (expq.size() > 0);
            check("out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                check("out_i", int'($signed(out_i)), expq[0].i);
                check("out_q", int'($signed(out_q)), expq[0].q);
                check("frame_start", int'(frame_start), int'(expq[0].fs));
            end
            check("scr_reset", int'(scr_reset), int'(exp_init));
            m_ready = !exp_init && (!m_valid || out_ready);
            check("in_ready", int'(in_ready), int'(m_ready));
            m_acc = in_valid && m_ready;
            check("scr_enable", int'(scr_enable), int'(m_acc));
            if (scr_reset) n_scr_reset++;
            if (m_valid && out_ready) begin
                if (expq[0].fs) n_fs++;
                void'(expq.pop_front());
            end
            exp_init = 1'b0;
            if (m_acc) begin
                if (!force_code_en) check("scr_code_phase", int'(scr_code), int'(seq_code(pos)));
                c  = scr_code[1] ? 1 : -1;
                d  = scr_code[0] ? 1 : -1;
                si = int'($signed(in_i));
                sq = int'($signed(in_q));
                expq.push_back('{sat(si * c - sq * d), sat(si * d + sq * c), pos == 0});
                if (pos == FL - 1) begin
                    pos = 0;
                    exp_init = 1'b1;
                end else begin
                    pos++;
                end
            end
        end
    end

    // Hold a chip on the input until it is accepted (bounded wait).
    task automatic push(input logic [W-1:0] di, input logic [W-1:0] dq);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_i = di;
        in_q = dq;
        guard = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 20) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got no accept expected accept at %0t", $time);
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return 12'h800;
            1:       return 12'h7FF;
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic [1:0]   code;
        int           exp_i;
        int           exp_q;
    } vec_t;

    vec_t vecs[5];
    int   hold_i, hold_q, stall_en;
    longint t0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{W'(100),   W'(-50),   2'b11,  150,   50};
        vecs[1] = '{W'(100),   W'(-50),   2'b00, -150,  -50};
        vecs[2] = '{W'(100),   W'(-50),   2'b10,   50, -150};
        vecs[3] = '{W'(-2048), W'(-2048), 2'b01, 4095,    0};
        vecs[4] = '{W'(-2048), W'(-2048), 2'b10, -4096,   0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_i = '0; in_q = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_i", int'(out_i), 0);
        check("rst_frame_start", int'(frame_start), 0);
        reset = 1'b0;
        #1;
        check("init_scr_reset", int'(scr_reset), 1);
        check("init_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("run_scr_reset", int'(scr_reset), 0);
        check("run_in_ready", int'(in_ready), 1);
        check("run_out_valid", int'(out_valid), 0);

        // Directed vectors with forced code values.
        for (int k = 0; k < 5; k++) begin
            force_code = vecs[k].code;
            push(vecs[k].i, vecs[k].q);
            in_valid = 1'b0;
            check("vec_valid", int'(out_valid), 1);
            check("vec_out_i", int'($signed(out_i)), vecs[k].exp_i);
            check("vec_out_q", int'($signed(out_q)), vecs[k].exp_q);
        end
        force_code_en = 1'b0;
        @(posedge clk); #1;

        // Backpressure: first output stalls, later chips wait, then stream.
        out_ready = 1'b0;
        push(W'(11), W'(-7));
        hold_i = int'($signed(out_i));
        hold_q = int'($signed(out_q));
        in_i = W'(22); in_q = W'(33);
        stall_en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_hold_i", int'($signed(out_i)), hold_i);
            check("bp_hold_q", int'($signed(out_q)), hold_q);
            if (scr_enable) stall_en++;
        end
        check("bp_stall_enables", stall_en, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(W'(22), W'(33));
        push(W'(-44), W'(55));
        push(W'(66), W'(-77));
        push(W'(-88), W'(-99));
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while an output is stalled.
        push(W'(5), W'(6));
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", int'(out_valid), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_scr_reset", int'(scr_reset), 1);
        check("mid_rst_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Frame wrap with FRAME_LEN=4: 10 chips back to back.
        n_scr_reset = 0;
        n_fs = 0;
        t0 = $time;
        for (int k = 0; k < 10; k++) begin
            push(W'(k * 37 - 100), W'(200 - k * 53));
            if (k == 0) check("post_rst_frame_start", int'(frame_start), 1);
        end
        in_valid = 1'b0;
        check("wrap_cycles", int'(($time - t0) / 10), 12);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_scr_resets", n_scr_reset, 2);
        check("wrap_frame_starts", n_fs, 3);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_i      = pick();
            in_q      = pick();
        end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scramble_mixer.md
Name: scramble_mixer

Overview:
- Complex chip multiplier directly downstream of the long-code scrambler.
- Accepts spread I/Q chips over a valid/ready handshake and advances the scrambler exactly once per accepted chip.
- Multiplies each chip by the complex scrambling code (±1 ± j) and emits registered, saturated I/Q chips with a frame-start marker.
- Owns radio-frame chip counting: pulses scrambler reset at every frame boundary so the code restarts at phase 0.

Parameters:
- WIDTH, 12, signed width of input I/Q chips.
- FRAME_LEN, 38400, chips per radio frame; code reset after chip FRAME_LEN-1.
- CNT_W, 16, width of the chip counter; must satisfy 2^CNT_W >= FRAME_LEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input chip valid
- in_ready  out  1  block can accept a chip this cycle
- in_i  in  WIDTH  signed input chip, real part
- in_q  in  WIDTH  signed input chip, imaginary part
- scr_enable  out  1  advance scrambler; high exactly on accept cycles
- scr_reset  out  1  reset scrambler to initial state
- scr_code  in  2  scrambler output; [1] real code, [0] imaginary code; 1 -> +1, 0 -> -1
- out_valid  out  1  output chip valid
- out_ready  in  1  downstream accepts output
- out_i  out  WIDTH+1  signed scrambled real part
- out_q  out  WIDTH+1  signed scrambled imaginary part
- frame_start  out  1  qualifies out_valid; high on chip 0 of each frame

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on port reset.
- States:
  - INIT: scr_reset=1, in_ready=0. Always lasts exactly 1 cycle, then goes to RUN.
  - RUN: normal operation.
- Reset: state=INIT, chip_cnt=0, out_valid=0, out_i=out_q=0, frame_start=0. scr_reset is therefore high in the first cycle after reset deasserts.
- in_ready is (state==RUN) && (!out_valid || out_ready). It is combinational.
- accept is in_valid && in_ready. scr_enable equals accept, combinationally.
- scr_code is sampled in the accept cycle, before the scrambler advances.
- Multiply, with c = code real sign and d = code imag sign:
  - re = in_i*c - in_q*d
  - im = in_i*d + in_q*c
  - Compute in WIDTH+2 bits, then saturate to the WIDTH+1 signed range: max 2^WIDTH-1, min -2^WIDTH.
  - Only +2^WIDTH can overflow; it clamps to 2^WIDTH-1.
- Latency: an accepted chip appears on out_i/out_q with out_valid=1 on the next clock edge.
- On accept, frame_start is registered as (chip_cnt==0).
- Output hold: while out_valid && !out_ready, out_i, out_q and frame_start hold stable and in_ready=0.
- Output drain: out_valid clears on out_ready unless a new chip is accepted in the same cycle; an accept in the same cycle reloads the output register (full throughput).
- Chip counter:
  - Increments on accept.
  - On accepting chip FRAME_LEN-1: chip_cnt wraps to 0 and state goes to INIT (one cycle of scr_reset, in_ready=0).
  - The output register still drains during INIT.
- Reset mid-frame: all state returns to reset values immediately. Any pending output is discarded. The next frame starts at chip 0 after INIT.
- scr_enable and scr_reset are never high in the same cycle.
- The scrambler's own valid output is ignored.

Test Plan:
- Reset release -> scr_reset=1 for exactly 1 cycle with in_ready=0; in_ready=1 from the next cycle; out_valid=0 throughout.
- in_i=100, in_q=-50:
  - code 2'b11 -> out_i=150, out_q=50
  - code 2'b00 -> out_i=-150, out_q=-50
  - code 2'b10 -> out_i=50, out_q=-150
  - In every case scr_enable is high for exactly the accept cycle, and output appears 1 cycle later.
- Saturation (WIDTH=12): in_i=in_q=-2048, code 2'b01 -> out_i=4095 (clamped), out_q=0; code 2'b10 -> out_i=-4096, out_q=0.
- Backpressure: stream 5 chips with out_ready=0 after the first -> first output holds stable; in_ready=0; scr_enable pulses exactly once; on out_ready=1 the remaining chips flow at 1/cycle in order.
- Frame wrap (FRAME_LEN=4): stream 10 chips continuously:
  - frame_start high on outputs 0, 4 and 8.
  - scr_reset pulses 1 cycle after accepting chips 3 and 7, with in_ready=0 in those cycles.
  - Codes restart at phase 0 each frame.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, chip_cnt=0; INIT follows; the next output carries frame_start=1.
